// File: rtl/core_ifu_pkg.sv
// Shared types and default sizing for the instruction-fetch prefetch unit.
package core_ifu_pkg;

  localparam int DEF_DATA_WIDTH      = 32;
  localparam int DEF_ADDR_WIDTH      = 32;
  localparam int DEF_DEPTH           = 8;
  localparam int DEF_MAX_OUTSTANDING = 4;

  // One returned fetch as it sits in the response buffer.
  typedef struct packed {
    logic                      err;
    logic [DEF_ADDR_WIDTH-1:0] pc;
    logic [DEF_DATA_WIDTH-1:0] data;
  } ifu_entry_t;

endpackage

// File: rtl/core_ifu_pf_chk.sv
// Overflow checks for the two prefetch queues; has no functional outputs.
module core_ifu_pf_chk (
  input logic clk,
  input logic rst,
  input logic aq_push,
  input logic aq_pop,
  input logic aq_full,
  input logic rb_push,
  input logic rb_pop,
  input logic rb_full
);

  a_aq_no_overflow: assert property (@(posedge clk) disable iff (rst) !(aq_push && aq_full && !aq_pop));
  a_rb_no_overflow: assert property (@(posedge clk) disable iff (rst) !(rb_push && rb_full && !rb_pop));

endmodule

// File: rtl/core_ifu_pf_fifo.sv
// Generic first-word-fall-through FIFO with synchronous clear; used both for
// in-flight fetch addresses and for returned instruction words.
module core_ifu_pf_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clr,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       pop_data,
  output logic                   empty,
  output logic                   full,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PW-1:0]    wr_ptr_r;
  logic [PW-1:0]    rd_ptr_r;
  logic [CW-1:0]    count_r;
  logic             push_s;
  logic             pop_s;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? {PW{1'b0}} : p + PW'(1'b1);
  endfunction

  // Qualify requests: a push into a full FIFO is only taken alongside a pop.
  always_comb begin
    pop_s    = pop & (count_r != {CW{1'b0}});
    push_s   = push & ((count_r != CW'(DEPTH)) | pop_s);
    pop_data = mem_r[rd_ptr_r];
    empty    = (count_r == {CW{1'b0}});
    full     = (count_r == CW'(DEPTH));
    count    = count_r;
  end

  // Pointer and occupancy update.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (push_s) wr_ptr_r <= ptr_next(wr_ptr_r);
      if (pop_s)  rd_ptr_r <= ptr_next(rd_ptr_r);
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CW'(1'b1);
        2'b01:   count_r <= count_r - CW'(1'b1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Storage array; contents need no reset since occupancy gates every read.
  always_ff @(posedge clk) begin
    if (push_s) mem_r[wr_ptr_r] <= push_data;
  end

endmodule

// File: rtl/core_ifu_prefetch.sv
// Instruction prefetch unit: issues fetches under credit control, tags in-order
// bus responses with their pc, and buffers them for the consumer; supports flush.
module core_ifu_prefetch
  import core_ifu_pkg::*;
#(
  parameter int DATA_WIDTH      = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH      = DEF_ADDR_WIDTH,
  parameter int DEPTH           = DEF_DEPTH,
  parameter int MAX_OUTSTANDING = DEF_MAX_OUTSTANDING
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  lsu_rx_valid,
  output logic                  lsu_rx_ready,
  input  logic [ADDR_WIDTH-1:0] lsu_rx_addr,
  output logic                  bus_req_valid,
  input  logic                  bus_req_ready,
  output logic [ADDR_WIDTH-1:0] bus_req_addr,
  input  logic                  bus_rsp_valid,
  input  logic [DATA_WIDTH-1:0] bus_rsp_data,
  input  logic                  bus_rsp_err,
  output logic                  lsu_tx_valid,
  input  logic                  lsu_tx_ready,
  output logic [DATA_WIDTH-1:0] lsu_tx_inst,
  output logic [ADDR_WIDTH-1:0] lsu_tx_pc,
  output logic                  lsu_tx_err,
  output logic                  proto_err
);

  localparam int EW = 1 + ADDR_WIDTH + DATA_WIDTH;
  localparam int IW = $clog2(MAX_OUTSTANDING) + 1;
  localparam int BW = $clog2(DEPTH) + 1;

  logic [IW-1:0]         inflight_s;
  logic [BW-1:0]         buf_count_s;
  logic [IW-1:0]         discard_cnt_r;
  logic                  proto_err_r;
  logic                  credit_ok_s;
  logic                  issue_s;
  logic                  rsp_ok_s;
  logic                  rsp_keep_s;
  logic                  tx_pop_s;
  logic                  aq_empty_s;
  logic                  aq_full_s;
  logic                  rb_empty_s;
  logic                  rb_full_s;
  logic [ADDR_WIDTH-1:0] rsp_pc_s;
  logic [EW-1:0]         rb_in_s;
  logic [EW-1:0]         rb_out_s;

  // Handshakes and response routing; credit uses registered counts only.
  always_comb begin
    credit_ok_s   = (int'(inflight_s) + int'(buf_count_s) < DEPTH) &&
                    (int'(inflight_s) < MAX_OUTSTANDING);
    bus_req_valid = lsu_rx_valid & credit_ok_s & ~flush & ~rst;
    lsu_rx_ready  = bus_req_ready & credit_ok_s & ~flush & ~rst;
    bus_req_addr  = lsu_rx_addr;
    issue_s       = bus_req_valid & bus_req_ready;
    rsp_ok_s      = bus_rsp_valid & ~aq_empty_s & ~rst;
    rsp_keep_s    = rsp_ok_s & (discard_cnt_r == {IW{1'b0}}) & ~flush;
    rb_in_s       = {bus_rsp_err, rsp_pc_s, bus_rsp_data};
    lsu_tx_valid  = ~rb_empty_s & ~flush & ~rst;
    tx_pop_s      = lsu_tx_valid & lsu_tx_ready;
    {lsu_tx_err, lsu_tx_pc, lsu_tx_inst} = rb_out_s;
    proto_err     = proto_err_r;
  end

  // Discard credit for fetches flushed while in flight, and the sticky protocol error.
  always_ff @(posedge clk) begin
    if (rst) begin
      discard_cnt_r <= {IW{1'b0}};
      proto_err_r   <= 1'b0;
    end else begin
      if (flush) begin
        discard_cnt_r <= inflight_s - IW'(rsp_ok_s);
      end else if (rsp_ok_s && (discard_cnt_r != {IW{1'b0}})) begin
        discard_cnt_r <= discard_cnt_r - IW'(1'b1);
      end else begin
        discard_cnt_r <= discard_cnt_r;
      end
      proto_err_r <= proto_err_r | (bus_rsp_valid & aq_empty_s);
    end
  end

  // The address queue occupancy doubles as the in-flight count.
  core_ifu_pf_fifo #(.WIDTH(ADDR_WIDTH), .DEPTH(MAX_OUTSTANDING)) u_addr_q (
    .clk       (clk),
    .rst       (rst),
    .clr       (1'b0),
    .push      (issue_s),
    .push_data (lsu_rx_addr),
    .pop       (rsp_ok_s),
    .pop_data  (rsp_pc_s),
    .empty     (aq_empty_s),
    .full      (aq_full_s),
    .count     (inflight_s)
  );

  core_ifu_pf_fifo #(.WIDTH(EW), .DEPTH(DEPTH)) u_rsp_buf (
    .clk       (clk),
    .rst       (rst),
    .clr       (flush),
    .push      (rsp_keep_s),
    .push_data (rb_in_s),
    .pop       (tx_pop_s),
    .pop_data  (rb_out_s),
    .empty     (rb_empty_s),
    .full      (rb_full_s),
    .count     (buf_count_s)
  );

  core_ifu_pf_chk u_chk (
    .clk     (clk),
    .rst     (rst),
    .aq_push (issue_s),
    .aq_pop  (rsp_ok_s),
    .aq_full (aq_full_s),
    .rb_push (rsp_keep_s),
    .rb_pop  (tx_pop_s),
    .rb_full (rb_full_s)
  );

endmodule

// File: doc/core_ifu_prefetch.md
CORE_IFU_PREFETCH -- requirements
Module: core_ifu_prefetch

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- DATA_WIDTH, 32, instruction word width.
- ADDR_WIDTH, 32, fetch address width.
- DEPTH, 8, response buffer entries; power of two, >=2.
- MAX_OUTSTANDING, 4, in-flight bus request limit; power of two, >=1, <=DEPTH.
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk  in  1  single clock; all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  discard all buffered and in-flight fetches.
- lsu_rx_valid  in  1  fetch request valid.
- lsu_rx_ready  out  1  fetch request accepted.
- lsu_rx_addr  in  ADDR_WIDTH  fetch address.
- bus_req_valid  out  1  bus request valid.
- bus_req_ready  in  1  bus accepts request.
- bus_req_addr  out  ADDR_WIDTH  bus request address.
- bus_rsp_valid  in  1  in-order bus response; no back-pressure.
- bus_rsp_data  in  DATA_WIDTH  response data.
- bus_rsp_err  in  1  response bus error.
- lsu_tx_valid  out  1  instruction available.
- lsu_tx_ready  in  1  consumer takes instruction.
- lsu_tx_inst  out  DATA_WIDTH  instruction word.
- lsu_tx_pc  out  ADDR_WIDTH  address the word was fetched from.
- lsu_tx_err  out  1  word carries bus error.
- proto_err  out  1  sticky: response received with nothing in flight.

Function
REQ-003 credit_ok SHALL equal (inflight + buf_count < DEPTH) AND (inflight < MAX_OUTSTANDING), from registered values only; there is no same-cycle pop bypass.
REQ-004 bus_req_valid SHALL equal lsu_rx_valid AND credit_ok AND NOT flush AND NOT rst, and SHALL NOT depend on bus_req_ready.
REQ-005 lsu_rx_ready SHALL equal bus_req_ready AND credit_ok AND NOT flush AND NOT rst.
REQ-006 bus_req_addr SHALL equal lsu_rx_addr; issue = bus_req_valid AND bus_req_ready.
REQ-007 On issue, the request address SHALL be pushed into the in-flight address queue (MAX_OUTSTANDING entries), and inflight increments.
REQ-008 Each bus_rsp_valid with inflight>0 SHALL pop the address queue and decrement inflight; issue and response in the same cycle leave inflight unchanged.
REQ-009 A response with discard_cnt=0 and no flush SHALL push {err, pc, data} into the response buffer. Otherwise it SHALL be dropped, with discard_cnt decremented if nonzero.
REQ-010 A response with inflight=0 SHALL be ignored and SHALL set proto_err until rst.
REQ-011 The response buffer SHALL be first-word-fall-through. Response at edge N SHALL appear on lsu_tx_* after edge N (1-cycle latency). lsu_tx_valid SHALL equal buffer-not-empty AND NOT flush.
REQ-012 A pop occurs on lsu_tx_valid AND lsu_tx_ready; simultaneous push and pop SHALL be legal at any occupancy.
REQ-013 Overflow SHALL be impossible by REQ-003; a push while full is a design assertion failure.
REQ-014 flush SHALL empty the response buffer in one cycle. It SHALL set discard_cnt to inflight minus (1 if a response arrives that cycle). It SHALL block issue and pop that cycle.
REQ-015 Back-to-back flushes SHALL recompute discard_cnt per REQ-014 and SHALL NOT accumulate.
REQ-016 Pointer and counter arithmetic SHALL wrap modulo the entry count. Counts SHALL be clog2(N)+1 bits wide.

Reset
REQ-017 While rst is high: both queues are emptied, and inflight, discard_cnt and proto_err are 0. lsu_tx_valid, bus_req_valid and lsu_rx_ready are 0.
REQ-018 rst mid-operation SHALL drop all in-flight state. Responses arriving after reset deassertion with inflight=0 follow REQ-010.

Structure
REQ-019 Shared package core_ifu_pkg SHALL hold the entry struct {err, pc, data} and the default width and depth constants.
REQ-020 One generic sub-module, core_ifu_pf_fifo (WIDTH, DEPTH, sync clear), SHALL be instantiated twice: once as the address queue and once as the response buffer.

Verification
REQ-021 The bench SHALL cover the following scenarios.
- Streaming: requests 0x100,0x104,... with bus_req_ready=1, 1-cycle bus latency, lsu_tx_ready=1. Expect 1 instruction per cycle, lsu_tx_pc in order, lsu_tx_inst matching.
- Credit stall: lsu_tx_ready=0, DEPTH=8, MAX_OUTSTANDING=4. Expect exactly 8 issues, then lsu_rx_ready=0 until one pop, then exactly 1 further issue.
- Flush with 3 in flight and 2 buffered: lsu_tx_valid=0 the next cycle. The next 3 responses are dropped. A request to 0x200 issued after the flush is returned as the next lsu_tx_pc=0x200.
- Flush in the same cycle as a response, with 2 in flight: that response and exactly 1 more are dropped.
- Bus error: bus_rsp_err=1 on the 2nd of 3 responses. Expect lsu_tx_err=1 only on the 2nd word.
- Stray response at inflight=0: proto_err=1 the next cycle and no buffer push. A rst pulse clears proto_err and all outputs to 0.
